// File: rtl/float_add_pkg.sv
// Shared binary32 field widths, special encodings and the operand unpacker
// used by the float_add pipeline.
package float_add_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;
    localparam int SIG_W  = FRAC_W + 1;
    localparam int ALN_W  = SIG_W + 3;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exponent;
        logic [SIG_W-1:0]  significand;
        logic              isZero;
        logic              isInf;
        logic              isNan;
    } operandT;

    // Exponent 0 is always zero here: subnormal inputs are flushed.
    function automatic operandT unpack(input logic [31:0] f);
        operandT op;
        op.sign        = f[31];
        op.exponent    = f[30:23];
        op.significand = {1'b1, f[22:0]};
        op.isZero      = (f[30:23] == '0);
        op.isInf       = (f[30:23] == '1) && (f[22:0] == '0);
        op.isNan       = (f[30:23] == '1) && (f[22:0] != '0);
        return op;
    endfunction

endpackage

// File: rtl/float_lzc.sv
// Combinational leading-zero counter over the 27-bit aligned sum; an
// all-zero input reports 27.
module float_lzc (
    input  logic [26:0] value,
    output logic [4:0]  count
);

    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (value[i]) count = 5'(26 - i);
        end
    end

endmodule

// File: rtl/float_add.sv
// Pipelined binary32 adder: input register, then align, add/normalize and
// round/pack stages. Result appears three edges after the input is sampled.
import float_add_pkg::*;

module float_add (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] floatA,
    input  logic [31:0] floatB,
    output logic        out_valid,
    output logic [31:0] floatSum
);

    logic              inValidReg, s1ValidReg, s2ValidReg;
    logic [31:0]       aReg, bReg;

    // S1: unpack, classify, swap, align
    operandT           opA, opB;
    logic              aGeB, effSub, specialNext;
    logic [31:0]       specialValNext;
    logic              bigSign;
    logic [EXP_W-1:0]  bigExp, smallExp, expDiff;
    logic [SIG_W-1:0]  bigSig, smallSig;
    logic [49:0]       alignWide;
    logic [ALN_W-1:0]  smallAligned;

    assign opA      = unpack(aReg);
    assign opB      = unpack(bReg);
    assign aGeB     = aReg[30:0] >= bReg[30:0];
    assign effSub   = opA.sign ^ opB.sign;
    assign bigSign  = aGeB ? opA.sign : opB.sign;
    assign bigExp   = aGeB ? opA.exponent : opB.exponent;
    assign smallExp = aGeB ? opB.exponent : opA.exponent;
    assign bigSig   = aGeB ? opA.significand : opB.significand;
    assign smallSig = aGeB ? opB.significand : opA.significand;
    assign expDiff  = bigExp - smallExp;
    assign alignWide = {smallSig, 26'b0} >> expDiff;
    // Top 26 bits are significand plus guard/round; everything below folds into sticky.
    assign smallAligned = (expDiff >= 8'd26) ? 27'd1 : {alignWide[49:24], |alignWide[23:0]};

    always_comb begin
        specialNext    = 1'b1;
        specialValNext = QNAN;
        if (opA.isNan || opB.isNan)                   specialValNext = QNAN;
        else if (opA.isInf && opB.isInf && effSub)    specialValNext = QNAN;
        else if (opA.isInf)                           specialValNext = aReg;
        else if (opB.isInf)                           specialValNext = bReg;
        else if (opA.isZero && opB.isZero)            specialValNext = {opA.sign & opB.sign, 31'b0};
        else if (opA.isZero)                          specialValNext = bReg;
        else if (opB.isZero)                          specialValNext = aReg;
        else                                          specialNext    = 1'b0;
    end

    logic              s1SpecialReg, s1SignReg, s1EffSubReg;
    logic [31:0]       s1SpecialValReg;
    logic [EXP_W-1:0]  s1ExpReg;
    logic [ALN_W-1:0]  s1BigReg, s1SmallReg;

    // S2: add/subtract, leading-zero count, normalize
    logic [ALN_W:0]    rawSum;
    logic [4:0]        leadZeros;
    logic [ALN_W-1:0]  normNext;
    logic signed [9:0] expNormNext;

    assign rawSum = s1EffSubReg ? ({1'b0, s1BigReg} - {1'b0, s1SmallReg})
                                : ({1'b0, s1BigReg} + {1'b0, s1SmallReg});

    float_lzc lzcInst (
        .value (rawSum[ALN_W-1:0]),
        .count (leadZeros)
    );

    always_comb begin
        if (rawSum[ALN_W]) begin
            normNext    = {rawSum[ALN_W:2], rawSum[1] | rawSum[0]};
            expNormNext = $signed({2'b0, s1ExpReg}) + 10'sd1;
        end else begin
            normNext    = rawSum[ALN_W-1:0] << leadZeros;
            expNormNext = $signed({2'b0, s1ExpReg}) - $signed({5'b0, leadZeros});
        end
    end

    logic              s2SpecialReg, s2SignReg, s2ZeroReg;
    logic [31:0]       s2SpecialValReg;
    logic signed [9:0] s2ExpReg;
    logic [ALN_W-1:0]  s2NormReg;

    // S3: round to nearest even, pack, special select
    logic              roundUp;
    logic [SIG_W:0]    mantRounded;
    logic signed [9:0] expRounded;
    logic [FRAC_W-1:0] fracRounded;
    logic [31:0]       resultNext;

    assign roundUp     = s2NormReg[2] & (s2NormReg[1] | s2NormReg[0] | s2NormReg[3]);
    assign mantRounded = {1'b0, s2NormReg[ALN_W-1:3]} + {{SIG_W{1'b0}}, roundUp};
    assign expRounded  = s2ExpReg + (mantRounded[SIG_W] ? 10'sd1 : 10'sd0);
    assign fracRounded = mantRounded[SIG_W] ? mantRounded[FRAC_W:1] : mantRounded[FRAC_W-1:0];

    always_comb begin
        resultNext = {s2SignReg, expRounded[EXP_W-1:0], fracRounded};
        if (s2SpecialReg)                                  resultNext = s2SpecialValReg;
        else if (s2ZeroReg)                                resultNext = 32'h0;
        else if (expRounded >= $signed(10'(2 * BIAS + 1))) resultNext = s2SignReg ? NEG_INF : POS_INF;
        else if (expRounded <= 10'sd0)                     resultNext = {s2SignReg, 31'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inValidReg <= 1'b0;
            s1ValidReg <= 1'b0;
            s2ValidReg <= 1'b0;
            out_valid  <= 1'b0;
            floatSum   <= 32'h0;
        end else begin
            inValidReg <= in_valid;
            s1ValidReg <= inValidReg;
            s2ValidReg <= s1ValidReg;
            out_valid  <= s2ValidReg;
            if (s2ValidReg) floatSum <= resultNext;
        end
    end

    always_ff @(posedge clk) begin
        aReg            <= floatA;
        bReg            <= floatB;
        s1SpecialReg    <= specialNext;
        s1SpecialValReg <= specialValNext;
        s1SignReg       <= bigSign;
        s1EffSubReg     <= effSub;
        s1ExpReg        <= bigExp;
        s1BigReg        <= {bigSig, 3'b0};
        s1SmallReg      <= smallAligned;
        s2SpecialReg    <= s1SpecialReg;
        s2SpecialValReg <= s1SpecialValReg;
        s2SignReg       <= s1SignReg;
        s2ZeroReg       <= (rawSum == '0);
        s2ExpReg        <= expNormNext;
        s2NormReg       <= normNext;
    end

endmodule

// File: tb/tb_float_add.sv
// Randomized bench for float_add: an exact wide-integer reference model
// predicts every sum; a scoreboard checks value, latency and hold behaviour.
module tb_float_add;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] floatA = 32'h0;
    logic [31:0] floatB = 32'h0;
    logic        out_valid;
    logic [31:0] floatSum;

    always #5 clk = ~clk;

    float_add dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .floatA    (floatA),
        .floatB    (floatB),
        .out_valid (out_valid),
        .floatSum  (floatSum)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] want;
        int          issue;
    } txnT;

    txnT         pending[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    logic        monOn = 1'b0;
    logic [31:0] lastSum = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Exact sum as integers in units of 2^-149, then round to 24 bits, ties to even.
    function automatic logic [31:0] refAdd(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] ma, mb, mag, rem, half, m;
        logic         s;
        int           p, sh, e;
        logic         za, zb, ia, ib, na, nb;
        za = (a[30:23] == 8'd0);
        zb = (b[30:23] == 8'd0);
        ia = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        ib = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        if (na || nb) return 32'h7FC00000;
        if (ia && ib && (a[31] != b[31])) return 32'h7FC00000;
        if (ia) return a;
        if (ib) return b;
        if (za && zb) return {a[31] & b[31], 31'b0};
        if (za) return b;
        if (zb) return a;
        ma = 300'({1'b1, a[22:0]}) << (a[30:23] - 8'd1);
        mb = 300'({1'b1, b[22:0]}) << (b[30:23] - 8'd1);
        if (a[31] == b[31]) begin
            mag = ma + mb; s = a[31];
        end else if (ma >= mb) begin
            mag = ma - mb; s = a[31];
        end else begin
            mag = mb - ma; s = b[31];
        end
        if (mag == '0) return 32'h0;
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) return {s, 31'b0};
        sh   = p - 23;
        m    = mag >> sh;
        rem  = mag & ((300'(1) << sh) - 300'(1));
        half = (sh > 0) ? (300'(1) << (sh - 1)) : '0;
        if (sh > 0 && (rem > half || (rem == half && m[0]))) m = m + 300'(1);
        e = p - 22;
        if (m[24]) begin
            m = m >> 1;
            e++;
        end
        if (e >= 255) return {s, 8'hFF, 23'b0};
        if (e <= 0) return {s, 31'b0};
        return {s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] randOperand(input logic [31:0] near);
        int          mode, e;
        logic [31:0] r;
        mode = int'($urandom_range(0, 15));
        r    = $urandom;
        if (mode == 0) begin
            case ($urandom_range(0, 5))
                0: r = 32'h00000000;
                1: r = 32'h80000000;
                2: r = 32'h7F800000;
                3: r = 32'hFF800000;
                4: r = {r[31], 8'hFF, 23'(int'($urandom_range(1, 32'h7FFFFF)))};
                default: r = {r[31], 8'h00, r[22:0]};
            endcase
        end else if (mode >= 4) begin
            e = int'(near[30:23]) + int'($urandom_range(0, 60)) - 30;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
            r = {r[31], 8'(e), r[22:0]};
        end
        return r;
    endfunction

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] want);
        floatA   = a;
        floatB   = b;
        in_valid = 1'b1;
        pending.push_back('{a, b, want, cyc + 1});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            if (out_valid) begin
                if (pending.size() == 0) begin
                    checkEq("spurious_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    txnT t;
                    t = pending.pop_front();
                    checkEq("sum", floatSum, t.want);
                    checkEq("latency", 32'(cyc - t.issue), 32'd3);
                    $display("txn a=%h b=%h sum=%h want=%h", t.a, t.b, floatSum, t.want);
                end
                lastSum = floatSum;
            end else begin
                checkEq("hold", floatSum, lastSum);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkEq("reset_valid", {31'b0, out_valid}, 32'd0);
        checkEq("reset_sum", floatSum, 32'h0);
        monOn = 1'b1;

        send(32'h00000000, 32'h00000000, 32'h00000000);
        idle(5);
        send(32'h3FC00000, 32'h40100000, 32'h40700000);
        send(32'h7F800000, 32'h40100000, 32'h7F800000);
        send(32'hFF800000, 32'h40100000, 32'hFF800000);
        send(32'h7F800000, 32'hFF800000, 32'h7FC00000);
        send(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        send(32'h3F800000, 32'hBF800000, 32'h00000000);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        send(32'h80000000, 32'h80000000, 32'h80000000);
        send(32'h80000000, 32'h00000000, 32'h00000000);
        send(32'h3F800000, 32'h33800000, 32'h3F800000);
        send(32'h3F800001, 32'h33800000, 32'h3F800002);
        send(32'h3F800000, 32'h2F800000, 32'h3F800000);
        send(32'hBF800000, 32'h40100000, 32'h3FA00000);
        idle(6);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle(1);
            end else begin
                a = randOperand($urandom);
                b = randOperand(a);
                send(a, b, refAdd(a, b));
            end
        end
        idle(6);

        // Reset lands while four pairs are in flight; none may emerge.
        send(32'h3F800000, 32'h33800000, 32'h3F800000);
        send(32'h3F800001, 32'h33800000, 32'h3F800002);
        send(32'h3F800000, 32'h2F800000, 32'h3F800000);
        floatA   = 32'h3FC00000;
        floatB   = 32'h40100000;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        pending.delete();
        lastSum  = 32'h0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h3FC00000, 32'h40100000, 32'h40700000);
        idle(10);

        checkEq("drain", 32'(pending.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
